// File: rtl/hdlc_pkg.sv
// Shared types and constants for the HDLC receive deframer.
// Detector state indices address bits of the 10-bit one-hot detector state vector.
package hdlc_pkg;

  localparam int S0   = 0;
  localparam int S1   = 1;
  localparam int S2   = 2;
  localparam int S3   = 3;
  localparam int S4   = 4;
  localparam int S5   = 5;
  localparam int S6   = 6;
  localparam int ERR  = 7;
  localparam int DISC = 8;
  localparam int FLAG = 9;
  localparam int DET_W = 10;

  localparam logic [7:0] FLAG_BYTE = 8'h7E;
  // Data bits are held back by the length of the flag prefix (0111111) so a flag never reaches the assembler.
  localparam int DELAY_LEN = $bits(FLAG_BYTE) - 1;

  typedef enum logic [1:0] {
    HUNT,
    OPEN,
    DATA
  } frame_state_e;

  typedef struct packed {
    logic       sof;
    logic       eof;
    logic       err;
    logic [7:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/hdlc_bitstuff_det.sv
// One-hot bit-stuffing / flag / abort detector, advanced once per accepted serial bit.
// Events are decoded from the next state so they coincide with the bit that causes them.
module hdlc_bitstuff_det
  import hdlc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic bit_i,
  input  logic valid_i,
  output logic flag_o,
  output logic abort_o,
  output logic data_o
);

  logic [DET_W-1:0] det_q;
  logic [DET_W-1:0] det_d;

  always_comb begin
    det_d       = '0;
    det_d[S1]   = bit_i & (det_q[S0] | det_q[DISC] | det_q[FLAG]);
    det_d[S2]   = bit_i & det_q[S1];
    det_d[S3]   = bit_i & det_q[S2];
    det_d[S4]   = bit_i & det_q[S3];
    det_d[S5]   = bit_i & det_q[S4];
    det_d[S6]   = bit_i & det_q[S5];
    det_d[ERR]  = bit_i & (det_q[S6] | det_q[ERR]);
    det_d[S0]   = ~bit_i & ~(det_q[S5] | det_q[S6]);
    det_d[DISC] = ~bit_i & det_q[S5];
    det_d[FLAG] = ~bit_i & det_q[S6];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      det_q <= DET_W'(1);
    end else if (valid_i) begin
      det_q <= det_d;
    end
  end

  // A long run of ones only aborts once; sitting in ERR is idle line.
  assign flag_o  = valid_i & det_d[FLAG];
  assign abort_o = valid_i & det_d[ERR] & ~det_q[ERR];
  assign data_o  = valid_i & (|det_d[S6:S0]);

endmodule

// File: rtl/hdlc_rx_deframer.sv
// HDLC receive deframer: destuffs the serial line, delimits frames on flags and aborts,
// assembles LSB-first bytes and delivers them through a small first-word-fall-through FIFO.
module hdlc_rx_deframer
  import hdlc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_BYTES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eof,
  output logic       out_err,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       in_frame,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0] MIN_B = 8'(MIN_BYTES);

  logic flagEv, abortEv, dataEv;

  hdlc_bitstuff_det u_det (
    .clk    (clk),
    .reset  (reset),
    .bit_i  (in_bit),
    .valid_i(in_valid),
    .flag_o (flagEv),
    .abort_o(abortEv),
    .data_o (dataEv)
  );

  frame_state_e state_q, state_d;
  logic [DELAY_LEN-1:0] dl_q, dl_d;
  logic [2:0] dlCnt_q, dlCnt_d;
  logic [6:0] asm_q, asm_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] pendData_q, pendData_d;
  logic pendSof_q, pendSof_d;
  logic [7:0] byteCnt_q, byteCnt_d;
  logic overflow_q, overflow_d;

  fifo_entry_t mem_q [FIFO_DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [AW:0] count_q;

  logic push, pop, canPush, writeEn, byteDone, clearPath;
  logic [7:0] newByte;
  fifo_entry_t pushEntry, head;

  assign pop     = out_valid & out_ready;
  assign canPush = (count_q < DEPTH_C) | pop;
  assign writeEn = push & canPush;

  always_comb begin
    state_d    = state_q;
    dl_d       = dl_q;
    dlCnt_d    = dlCnt_q;
    asm_d      = asm_q;
    bitCnt_d   = bitCnt_q;
    pendData_d = pendData_q;
    pendSof_d  = pendSof_q;
    byteCnt_d  = byteCnt_q;
    overflow_d = overflow_q;
    push       = 1'b0;
    pushEntry  = '0;
    byteDone   = 1'b0;
    clearPath  = 1'b0;
    newByte    = {dl_q[0], asm_q};

    if (dataEv && state_q != HUNT) begin
      dl_d = {in_bit, dl_q[DELAY_LEN-1:1]};
      if (dlCnt_q != 3'(DELAY_LEN)) begin
        dlCnt_d = dlCnt_q + 3'd1;
      end else begin
        asm_d    = {dl_q[0], asm_q[6:1]};
        bitCnt_d = bitCnt_q + 3'd1;
        byteDone = (bitCnt_q == 3'd7);
      end
    end

    case (state_q)
      HUNT: begin
        if (flagEv) begin
          clearPath = 1'b1;
          state_d   = OPEN;
        end
      end
      OPEN: begin
        if (flagEv) begin
          clearPath = 1'b1;
        end else if (abortEv) begin
          clearPath = 1'b1;
          state_d   = HUNT;
        end else if (byteDone) begin
          pendData_d = newByte;
          pendSof_d  = 1'b1;
          byteCnt_d  = 8'd1;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (flagEv) begin
          push      = 1'b1;
          pushEntry = '{sof: pendSof_q, eof: 1'b1,
                        err: (bitCnt_q != 3'd0) || (byteCnt_q < MIN_B), data: pendData_q};
          clearPath = 1'b1;
          state_d   = OPEN;
        end else if (abortEv) begin
          push      = 1'b1;
          pushEntry = '{sof: pendSof_q, eof: 1'b1, err: 1'b1, data: pendData_q};
          clearPath = 1'b1;
          state_d   = HUNT;
        end else if (byteDone) begin
          push       = 1'b1;
          pushEntry  = '{sof: pendSof_q, eof: 1'b0, err: 1'b0, data: pendData_q};
          pendData_d = newByte;
          pendSof_d  = 1'b0;
          if (byteCnt_q != 8'hFF) byteCnt_d = byteCnt_q + 8'd1;
        end
      end
      default: state_d = HUNT;
    endcase

    // A dropped byte leaves the frame unrecoverable, so resynchronise on the next flag.
    if (push && !canPush) begin
      overflow_d = 1'b1;
      state_d    = HUNT;
      clearPath  = 1'b1;
    end

    if (clearPath) begin
      dl_d     = '0;
      dlCnt_d  = '0;
      asm_d    = '0;
      bitCnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HUNT;
      dl_q       <= '0;
      dlCnt_q    <= '0;
      asm_q      <= '0;
      bitCnt_q   <= '0;
      pendData_q <= '0;
      pendSof_q  <= 1'b0;
      byteCnt_q  <= '0;
      overflow_q <= 1'b0;
    end else if (in_valid) begin
      state_q    <= state_d;
      dl_q       <= dl_d;
      dlCnt_q    <= dlCnt_d;
      asm_q      <= asm_d;
      bitCnt_q   <= bitCnt_d;
      pendData_q <= pendData_d;
      pendSof_q  <= pendSof_d;
      byteCnt_q  <= byteCnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (writeEn) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop) rdPtr_q <= rdPtr_q + AW'(1);
      case ({writeEn, pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (writeEn) mem_q[wrPtr_q] <= pushEntry;
  end

  assign head      = mem_q[rdPtr_q];
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? head.data : 8'h00;
  assign out_sof   = out_valid & head.sof;
  assign out_eof   = out_valid & head.eof;
  assign out_err   = out_valid & head.err;
  assign in_frame  = (state_q != HUNT);
  assign overflow  = overflow_q;

endmodule
